// File: rtl/game_session_ctrl_if.sv
// Game session bus: keyboard strobe, engine status and scores in,
// engine resets, video select, score display and high score out.
interface game_session_ctrl_if;
  logic        valid;
  logic [7:0]  keyboard;
  logic [3:0]  game_over;
  logic [13:0] score0;
  logic [13:0] score1;
  logic [13:0] score2;
  logic [13:0] score3;
  logic [3:0]  game_rst;
  logic [2:0]  video_sel;
  logic [13:0] score_out;
  logic [1:0]  active_game;
  logic [13:0] high_score;

  modport master (
    output valid, keyboard, game_over,
    output score0, score1, score2, score3,
    input  game_rst, video_sel, score_out,
    input  active_game, high_score
  );

  modport slave (
    input  valid, keyboard, game_over,
    input  score0, score1, score2, score3,
    output game_rst, video_sel, score_out,
    output active_game, high_score
  );
endinterface

// File: rtl/game_session_ctrl.sv
// Session FSM: blank wait, menu select, run one of four engines,
// death screen. Ports: clk, rst (async high), bus (slave modport).
// Optional macro GAME_HIGH_SCORE_EN keeps a per-engine best-score table.
module game_session_ctrl #(
  parameter int WAIT_CYCLES = 1024,
  parameter int OVER_HOLD   = 4096
) (
  input logic clk,
  input logic rst,
  game_session_ctrl_if.slave bus
);

  localparam int WW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam int HW = (OVER_HOLD > 2) ? $clog2(OVER_HOLD) : 1;
  localparam logic [WW-1:0] W_MAX = WW'(WAIT_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX = HW'(OVER_HOLD - 1);

  localparam logic [7:0] K_BRK = 8'hF0;
  localparam logic [7:0] K_E0  = 8'h16;
  localparam logic [7:0] K_E1  = 8'h1E;
  localparam logic [7:0] K_E2  = 8'h26;
  localparam logic [7:0] K_E3  = 8'h25;
  localparam logic [7:0] K_ESC = 8'h76;
  localparam logic [7:0] K_ENT = 8'h5A;

  typedef enum logic [1:0] {
    S_WAIT,
    S_SELECT,
    S_RUN,
    S_OVER
  } state_t;

  state_t       state;
  logic [WW-1:0] wcnt;
  logic [HW-1:0] hcnt;
  logic         brk;
  logic [1:0]   ag;
  logic [13:0]  score_q;
  logic [2:0]   vsel_q;
  logic [3:0]   grst_q;

  logic [13:0] sc [4];
  logic [13:0] cur_score;
  logic        make;
  logic        sel_hit;
  logic [1:0]  sel_idx;
  logic        exit_run;
  logic        enter_ok;

  assign sc[0] = bus.score0;
  assign sc[1] = bus.score1;
  assign sc[2] = bus.score2;
  assign sc[3] = bus.score3;

  assign cur_score = sc[ag];

  // A make code is a valid byte that is neither the break prefix
  // nor the byte consumed right after it.
  assign make = bus.valid && !brk && (bus.keyboard != K_BRK);

  always_comb begin
    sel_hit = 1'b0;
    sel_idx = 2'd0;
    if (make) begin
      case (bus.keyboard)
        K_E0: begin sel_hit = 1'b1; sel_idx = 2'd0; end
        K_E1: begin sel_hit = 1'b1; sel_idx = 2'd1; end
        K_E2: begin sel_hit = 1'b1; sel_idx = 2'd2; end
        K_E3: begin sel_hit = 1'b1; sel_idx = 2'd3; end
        default: ;
      endcase
    end
  end

  // game_over of the active engine and Esc both end the run; when they
  // coincide the key has no further effect.
  assign exit_run = (state == S_RUN) &&
                    (bus.game_over[ag] ||
                     (make && bus.keyboard == K_ESC));

  assign enter_ok = (state == S_OVER) && (hcnt == H_MAX) &&
                    make && (bus.keyboard == K_ENT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_WAIT;
      wcnt    <= '0;
      hcnt    <= '0;
      brk     <= 1'b0;
      ag      <= 2'd0;
      score_q <= '0;
      vsel_q  <= 3'd0;
      grst_q  <= 4'hF;
    end else begin
      if (bus.valid)
        brk <= brk ? 1'b0 : (bus.keyboard == K_BRK);
      unique case (state)
        S_WAIT: begin
          if (wcnt == W_MAX) begin
            state  <= S_SELECT;
            vsel_q <= 3'd1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_SELECT: begin
          if (sel_hit) begin
            state  <= S_RUN;
            ag     <= sel_idx;
            grst_q <= ~(4'b0001 << sel_idx);
            vsel_q <= 3'd2 + {1'b0, sel_idx};
          end
        end
        S_RUN: begin
          score_q <= cur_score;
          if (exit_run) begin
            state  <= S_OVER;
            grst_q <= 4'hF;
            vsel_q <= 3'd6;
            hcnt   <= '0;
          end
        end
        S_OVER: begin
          if (enter_ok) begin
            state  <= S_SELECT;
            vsel_q <= 3'd1;
            hcnt   <= '0;
          end else if (hcnt != H_MAX) begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  assign bus.game_rst    = grst_q;
  assign bus.video_sel   = vsel_q;
  assign bus.score_out   = score_q;
  assign bus.active_game = ag;

`ifdef GAME_HIGH_SCORE_EN
  logic [13:0] tbl [4];
  logic [13:0] hs_q;

  // hs_q mirrors tbl[active_game]; it is reloaded when the engine
  // changes and updated together with the table entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl  <= '{default: '0};
      hs_q <= '0;
    end else begin
      if (state == S_SELECT && sel_hit)
        hs_q <= tbl[sel_idx];
      if (exit_run && (cur_score > tbl[ag])) begin
        tbl[ag] <= cur_score;
        hs_q    <= cur_score;
      end
    end
  end

  assign bus.high_score = hs_q;
`else
  assign bus.high_score = '0;
`endif

endmodule

// File: doc/game_session_ctrl.md
GAME_SESSION_CTRL -- requirements
Module: game_session_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1024: power-up blank time in clk cycles before the menu is shown.
REQ-002 Parameter OVER_HOLD, default 4096: minimum clk cycles spent in the death screen before Enter is accepted.
REQ-003 clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 valid  input  1  one-cycle strobe; keyboard holds a new PS/2 scan code.
REQ-006 keyboard  input  8  PS/2 set-2 scan code.
REQ-007 game_over  input  4  per-engine game-over flags; bit i belongs to engine i.
REQ-008 score0..score3  input  14 each  live score of engines 0..3.
REQ-009 game_rst  output  4  per-engine reset; 1 holds the engine in reset.
REQ-010 video_sel  output  3  RGB source select: 0 black, 1 menu, 2..5 engine 0..3, 6 death screen.
REQ-011 score_out  output  14  score routed to the seven-segment display.
REQ-012 active_game  output  2  index of the selected engine.
REQ-013 high_score  output  14  best score recorded for active_game.

Function
REQ-014 States: WAIT, SELECT, RUN, OVER; all outputs are registered.
REQ-015 WAIT: video_sel=0, game_rst=4'b1111; the counter runs to WAIT_CYCLES-1, then the block moves to SELECT on the next cycle.
REQ-016 SELECT: video_sel=1; a valid make code selects an engine: 0x16 -> engine 0, 0x1E -> 1, 0x26 -> 2, 0x25 -> 3.
- active_game is loaded with the engine index.
- game_rst[i] clears on the next cycle; the block enters RUN.
REQ-017 SELECT: any other valid code is ignored; the block stays in SELECT.
REQ-018 Break filter: a valid 0xF0 sets a pending flag; the next valid code is consumed as a break code, clears the flag, and is never acted on.
- The filter is active in all states.
REQ-019 RUN: video_sel=2+active_game; score_out follows score[active_game] every cycle, one-cycle latency.
REQ-020 RUN exits to OVER when either occurs:
- game_over[active_game]=1;
- a valid make code 0x76 (Esc) arrives.
On the exit cycle, game_rst[active_game] returns to 1 and score_out freezes at that cycle's score.
REQ-021 RUN: game_over bits of non-active engines are ignored.
REQ-022 RUN: if game_over and a valid key arrive in the same cycle, game_over wins; the key is discarded.
REQ-023 OVER: video_sel=6; the hold counter counts from 0.
- Before it reaches OVER_HOLD-1, all keys are ignored.
- After that, a valid 0x5A (Enter) returns to SELECT and clears the counter.
- score_out holds its value.
REQ-024 At most one game_rst bit is 0 at any time; all bits are 1 outside RUN.
REQ-025 Both counters saturate and never wrap.

Reset
REQ-026 While rst=1, asynchronously: state=WAIT; counters, break flag, active_game, score_out and video_sel=0; game_rst=4'b1111; high-score table cleared.
REQ-027 Reset asserted mid-RUN forces game_rst=4'b1111 within the same cycle, with no dependence on clk.
REQ-028 After rst deasserts, the WAIT sequence restarts from zero.

Configuration
REQ-029 Macro GAME_HIGH_SCORE_EN defined: a 4x14-bit table is kept.
- On each RUN->OVER exit, if the frozen score > table[active_game], the table entry is updated and visible on the next cycle.
- high_score = table[active_game].
REQ-030 GAME_HIGH_SCORE_EN undefined: no table is built; high_score is tied to 0.

Verification
REQ-031 Reset release, WAIT_CYCLES=16 -> video_sel=0 for 16 cycles, then video_sel=1; game_rst=4'b1111 throughout.
REQ-032 In SELECT, valid 0x1E -> next cycle game_rst=4'b1101, active_game=1, video_sel=3; score1=37 -> score_out=37 one cycle later.
REQ-033 In RUN on engine 1: game_over=4'b0001 -> no change; game_over=4'b0010 together with valid 0x76 -> OVER, game_rst=4'b1111, score_out frozen.
REQ-034 In SELECT: valid 0xF0 then valid 0x16 -> stays in SELECT; a following valid 0x16 -> RUN on engine 0.
REQ-035 In OVER with OVER_HOLD=8: Enter on cycle 3 -> ignored; Enter on cycle 9 -> SELECT.
REQ-036 With GAME_HIGH_SCORE_EN defined: engine 2 run ends at 50, then at 20 -> high_score=50; rst pulse -> high_score=0.
